instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and runs the read/busywait handshake with instruction memory.
- Drives PC, nextPC, Instruction and Insthit into the IF/ID pipeline register; Insthit=0 marks a bubble.
- Branch/jump redirects from the ALU stage kill in-flight and buffered fetches.
- One output buffer plus one skid entry absorb downstream stalls without dropping a completed read.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on Instruction when Insthit=0

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low reset
stall  in  1  1 = IF/ID register will not capture this cycle (pipeline busywait or hazard)
branch_taken  in  1  redirect request from ALU stage
branch_target  in  32  redirect address; bits [1:0] forced to 0
imem_busywait  in  1  instruction memory busy
imem_readdata  in  32  instruction word, valid when imem_read=1 and imem_busywait=0
imem_read  out  1  read request
imem_address  out  32  read address, stable while imem_read=1
PC  out  32  address of the presented instruction
nextPC  out  32  PC+4
Instruction  out  32  presented instruction
Insthit  out  1  presented instruction is valid

Behaviour:
- State registers:
  - pc_reg: next address to fetch.
  - req_addr.
  - buffer: buf_pc, buf_instr, buf_valid.
  - skid: sk_pc, sk_instr.
  - kill flag.
  - FSM {BOOT, REQ, SKID}.
- Outputs are registered:
  - PC=buf_pc; nextPC=buf_pc+4, modulo 2^32.
  - Instruction=buf_valid ? buf_instr : NOP_INSTR; Insthit=buf_valid.
  - imem_read=1 only in REQ; imem_address=req_addr.
- Reset (reset=0 at posedge) has priority over everything:
  - pc_reg=req_addr=buf_pc=RESET_PC; buf_valid=0; kill=0; state=BOOT.
  - Outputs: PC=RESET_PC, nextPC=RESET_PC+4, Instruction=NOP_INSTR, Insthit=0, imem_read=0.
- Completion = state REQ and imem_busywait=0 in the same cycle.
- Accept = !stall || !buf_valid.
- BOOT: imem_read=0 for one cycle; req_addr<=pc_reg; go to REQ.
- REQ, on completion with no kill:
  - If accept: buffer<={req_addr, imem_readdata, 1}.
  - Else: skid<={req_addr, imem_readdata}, go to SKID.
  - In both cases: pc_reg<=req_addr+4; req_addr<=req_addr+4.
- REQ, on completion with kill=1: discard data; kill<=0; req_addr<=pc_reg; stay in REQ.
- REQ, no completion: req_addr held; if !stall then buf_valid<=0 (bubble).
- SKID: imem_read=0. When !stall: buffer<=skid, valid; go to REQ with req_addr=pc_reg.
- Redirect (branch_taken=1, reset inactive) overrides stall:
  - pc_reg<=target; buf_valid<=0; skid discarded.
  - REQ without completion: kill<=1; req_addr held so the outstanding read finishes at the same address.
  - REQ with completion: data discarded; req_addr<=target; kill stays 0.
  - SKID: go to REQ; req_addr<=target.
  - BOOT: pc_reg<=target; proceed to REQ normally.
- Redirect while kill=1: only the target is updated.
- Throughput and latency:
  - Zero-wait memory: one instruction per cycle.
  - First valid Insthit appears 2 cycles after reset release.
  - Each busywait cycle adds one bubble.
- No instruction is lost or duplicated across any stall/busywait combination.
- Wrap-around: 32'hFFFF_FFFC+4 wraps to 0 with no flag.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds output ports fetch_cnt[31:0] and bubble_cnt[31:0], both cleared on reset and wrapping at 2^32.
  - fetch_cnt increments on each non-killed completion.
  - bubble_cnt increments each cycle with !stall and Insthit=0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, zero-wait memory returning addr^32'hA5A5_0000 -> Insthit=1 from cycle 2; PC sequence 0,4,8,C; Instruction matches; nextPC=PC+4.
- imem_busywait=1 for 3 cycles on address 8 -> 3 bubbles (Insthit=0, Instruction=32'h13); imem_address stays 8; then PC=8 is presented once.
- stall=1 for 4 cycles during zero-wait fetch of 0x10 -> outputs frozen at 0x0C; 0x10 held in skid; imem_read=0; after release, PC=0x10 then 0x14 with no gaps or duplicates.
- branch_taken with target 0x100 while address 0x20 is busywaiting 2 more cycles -> 0x20 data discarded; next imem_address=0x100; no Insthit for 0x20.
- branch_taken with target 0x203 coincident with completion while stalled -> buffer and skid cleared; next fetch address 0x200.
- reset=0 asserted mid-busywait, with IFU_PERF_CNT_EN defined -> next cycle PC=0, Insthit=0, imem_read=0, counters=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC ownership, imem read/busywait handshake, output buffer plus skid entry.
// Optional performance counters (fetch_cnt, bubble_cnt) are enabled with `define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_busywait,
  input  logic [31:0] imem_readdata,
  output logic        imem_read,
  output logic [31:0] imem_address,
  output logic [31:0] PC,
  output logic [31:0] nextPC,
  output logic [31:0] Instruction,
  output logic        Insthit
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_SKID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_q, req_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic [31:0] sk_instr_q, sk_instr_d;
  logic        kill_q, kill_d;

  logic        complete;
  logic        accept;
  logic        kept;
  logic [31:0] target;

  assign complete = (state_q == S_REQ) && !imem_busywait;
  assign accept   = !stall || !buf_valid_q;
  assign target   = branch_target & ~32'h0000_0003;
  // A completion only produces an instruction if neither an older nor a same-cycle redirect voids it.
  assign kept     = complete && !kill_q && !branch_taken;

  assign imem_read    = (state_q == S_REQ);
  assign imem_address = req_q;
  assign PC           = buf_pc_q;
  assign nextPC       = buf_pc_q + 32'd4;
  assign Instruction  = buf_valid_q ? buf_instr_q : NOP_INSTR;
  assign Insthit      = buf_valid_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    buf_valid_d = buf_valid_q;
    sk_pc_d     = sk_pc_q;
    sk_instr_d  = sk_instr_q;
    kill_d      = kill_q;

    if (branch_taken) begin
      pc_d        = target;
      buf_valid_d = 1'b0;
      case (state_q)
        S_BOOT: begin
          req_d   = target;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (kill_q) begin
            // The killed read is still outstanding; once it lands, fetch resumes at the newest target.
            if (complete) begin
              kill_d = 1'b0;
              req_d  = target;
            end
          end else if (complete) begin
            req_d = target;
          end else begin
            kill_d = 1'b1;
          end
        end
        S_SKID: begin
          req_d   = target;
          state_d = S_REQ;
        end
        default: state_d = S_BOOT;
      endcase
    end else begin
      case (state_q)
        S_BOOT: begin
          req_d   = pc_q;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (complete) begin
            if (kill_q) begin
              kill_d = 1'b0;
              req_d  = pc_q;
            end else begin
              if (accept) begin
                buf_pc_d    = req_q;
                buf_instr_d = imem_readdata;
                buf_valid_d = 1'b1;
              end else begin
                sk_pc_d    = req_q;
                sk_instr_d = imem_readdata;
                state_d    = S_SKID;
              end
              pc_d  = req_q + 32'd4;
              req_d = req_q + 32'd4;
            end
          end else if (!stall) begin
            buf_valid_d = 1'b0;
          end
        end
        S_SKID: begin
          if (!stall) begin
            buf_pc_d    = sk_pc_q;
            buf_instr_d = sk_instr_q;
            buf_valid_d = 1'b1;
            req_d       = pc_q;
            state_d     = S_REQ;
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      req_q       <= RESET_PC;
      buf_pc_q    <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_valid_q <= 1'b0;
      sk_pc_q     <= RESET_PC;
      sk_instr_q  <= NOP_INSTR;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      buf_valid_q <= buf_valid_d;
      sk_pc_q     <= sk_pc_d;
      sk_instr_q  <= sk_instr_d;
      kill_q      <= kill_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      if (kept)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!stall && !buf_valid_q)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_kept;
  assign unused_kept = kept;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory returns addr ^ 32'hA5A5_0000 whenever not busy.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_busywait;
  logic [31:0] imem_readdata;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] PC;
  logic [31:0] nextPC;
  logic [31:0] Instruction;
  logic        Insthit;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  assign imem_readdata = imem_address ^ 32'hA5A5_0000;

  instr_fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_busywait(imem_busywait),
    .imem_readdata(imem_readdata),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .PC           (PC),
    .nextPC       (nextPC),
    .Instruction  (Instruction),
    .Insthit      (Insthit)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .bubble_cnt   (bubble_cnt)
`endif
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the presented instruction slot: valid entry at pc, or a bubble.
  task automatic chk_out(input string tag, input logic hit, input logic [31:0] pc);
    chk({tag, ".Insthit"}, {31'd0, Insthit}, {31'd0, hit});
    if (hit) begin
      chk({tag, ".PC"}, PC, pc);
      chk({tag, ".nextPC"}, nextPC, pc + 32'd4);
      chk({tag, ".Instr"}, Instruction, pc ^ 32'hA5A5_0000);
    end else begin
      chk({tag, ".Instr"}, Instruction, 32'h0000_0013);
    end
    $display("step %s: Insthit=%0b PC=%h Instr=%h imem_read=%0b imem_addr=%h",
             tag, Insthit, PC, Instruction, imem_read, imem_address);
  endtask

  task automatic chk_mem(input string tag, input logic rd, input logic [31:0] addr);
    chk({tag, ".imem_read"}, {31'd0, imem_read}, {31'd0, rd});
    if (rd) chk({tag, ".imem_addr"}, imem_address, addr);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    branch_target = 32'h0; imem_busywait = 1'b0;

    // Reset state
    step();
    chk_out("rst", 1'b0, 32'h0);
    chk("rst.PC", PC, 32'h0);
    chk("rst.nextPC", nextPC, 32'h4);
    chk_mem("rst", 1'b0, 32'h0);
    reset = 1'b1;

    step();  // BOOT -> REQ
    chk_out("boot", 1'b0, 32'h0);
    chk_mem("boot", 1'b1, 32'h0);
    step(); chk_out("seq0", 1'b1, 32'h0);  chk_mem("seq0", 1'b1, 32'h4);
    step(); chk_out("seq4", 1'b1, 32'h4);  chk_mem("seq4", 1'b1, 32'h8);

    // Three busywait cycles on address 8
    imem_busywait = 1'b1;
    step(); chk_out("bw1", 1'b0, 32'h0); chk_mem("bw1", 1'b1, 32'h8);
    step(); chk_out("bw2", 1'b0, 32'h0); chk_mem("bw2", 1'b1, 32'h8);
    step(); chk_out("bw3", 1'b0, 32'h0); chk_mem("bw3", 1'b1, 32'h8);
    imem_busywait = 1'b0;
    step(); chk_out("seq8", 1'b1, 32'h8);  chk_mem("seq8", 1'b1, 32'hC);
    step(); chk_out("seqC", 1'b1, 32'hC);  chk_mem("seqC", 1'b1, 32'h10);

    // Four stall cycles; 0x10 completes into the skid
    stall = 1'b1;
    step(); chk_out("st1", 1'b1, 32'hC); chk_mem("st1", 1'b0, 32'h0);
    step(); chk_out("st2", 1'b1, 32'hC); chk_mem("st2", 1'b0, 32'h0);
    step(); chk_out("st3", 1'b1, 32'hC); chk_mem("st3", 1'b0, 32'h0);
    step(); chk_out("st4", 1'b1, 32'hC); chk_mem("st4", 1'b0, 32'h0);
    stall = 1'b0;
    step(); chk_out("sk10", 1'b1, 32'h10); chk_mem("sk10", 1'b1, 32'h14);
    step(); chk_out("seq14", 1'b1, 32'h14); chk_mem("seq14", 1'b1, 32'h18);
    step(); chk_out("seq18", 1'b1, 32'h18);
    step(); chk_out("seq1C", 1'b1, 32'h1C); chk_mem("seq1C", 1'b1, 32'h20);

    // Redirect to 0x100 while 0x20 busywaits two more cycles
    imem_busywait = 1'b1;
    step(); chk_out("kbw", 1'b0, 32'h0); chk_mem("kbw", 1'b1, 32'h20);
    branch_taken = 1'b1; branch_target = 32'h100;
    step(); chk_out("kbr", 1'b0, 32'h0); chk_mem("kbr", 1'b1, 32'h20);
    branch_taken = 1'b0;
    step(); chk_out("kwait", 1'b0, 32'h0); chk_mem("kwait", 1'b1, 32'h20);
    imem_busywait = 1'b0;
    step(); chk_out("kdrop", 1'b0, 32'h0); chk_mem("kdrop", 1'b1, 32'h100);
    step(); chk_out("t100", 1'b1, 32'h100); chk_mem("t100", 1'b1, 32'h104);
    step(); chk_out("t104", 1'b1, 32'h104); chk_mem("t104", 1'b1, 32'h108);

    // Redirect to 0x203 coincident with a completion while stalled
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h203;
    step(); chk_out("bc", 1'b0, 32'h0); chk_mem("bc", 1'b1, 32'h200);
    branch_taken = 1'b0;
    step(); chk_out("t200", 1'b1, 32'h200); chk_mem("t200", 1'b1, 32'h204);
    step(); chk_out("sk204", 1'b1, 32'h200); chk_mem("sk204", 1'b0, 32'h0);

    // Redirect out of SKID discards the skid entry (0x204)
    branch_taken = 1'b1; branch_target = 32'h300;
    step(); chk_out("bsk", 1'b0, 32'h0); chk_mem("bsk", 1'b1, 32'h300);
    branch_taken = 1'b0; stall = 1'b0;
    step(); chk_out("t300", 1'b1, 32'h300); chk_mem("t300", 1'b1, 32'h304);

    // Wrap-around at the top of the address space
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    step(); chk_out("bwrap", 1'b0, 32'h0); chk_mem("bwrap", 1'b1, 32'hFFFF_FFFC);
    branch_taken = 1'b0;
    step(); chk_out("wrapFC", 1'b1, 32'hFFFF_FFFC); chk_mem("wrapFC", 1'b1, 32'h0);
    chk("wrap.nextPC", nextPC, 32'h0);
    chk("wrap.Instr", Instruction, 32'h5A5A_FFFC);
    step(); chk_out("wrap0", 1'b1, 32'h0); chk_mem("wrap0", 1'b1, 32'h4);

    // Reset asserted mid-busywait
    imem_busywait = 1'b1;
    step(); chk_out("rbw", 1'b0, 32'h0); chk_mem("rbw", 1'b1, 32'h4);
    reset = 1'b0;
    step();
    chk_out("rmid", 1'b0, 32'h0);
    chk("rmid.PC", PC, 32'h0);
    chk("rmid.nextPC", nextPC, 32'h4);
    chk_mem("rmid", 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("rmid.fetch_cnt", fetch_cnt, 32'h0);
    chk("rmid.bubble_cnt", bubble_cnt, 32'h0);
`endif
    reset = 1'b1; imem_busywait = 1'b0;
    step(); chk_out("rboot", 1'b0, 32'h0); chk_mem("rboot", 1'b1, 32'h0);
    step(); chk_out("rseq0", 1'b1, 32'h0); chk_mem("rseq0", 1'b1, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
